// File: rtl/ti_share_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ti_pkg
// Purpose  : Shared constants, types and the share-refresh function used by
//            the threshold-implemented (TI) S-box pipeline.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ti_pkg;

    localparam int NSHARE = 3;                  // Boolean shares
    localparam int WIDTH  = 4;                  // bits per share
    localparam int SHW    = NSHARE * WIDTH;     // full shared word
    localparam int RNDW   = (NSHARE - 1) * WIDTH; // fresh mask bits per word

    typedef logic [SHW-1:0]  share_word_t;
    typedef logic [RNDW-1:0] rnd_word_t;

    // Remask a shared word: share i (i < NSHARE-1) takes mask r_i, the last
    // share takes the XOR of all masks, so the XOR of all shares is preserved.
    // Only masks are ever accumulated, never the shares themselves.
    function automatic share_word_t share_refresh(input share_word_t w,
                                                  input rnd_word_t   r);
        share_word_t      res;
        logic [WIDTH-1:0] acc;
        res = w;
        acc = '0;
        for (int i = 0; i < NSHARE - 1; i++) begin
            res[WIDTH*i +: WIDTH] = w[WIDTH*i +: WIDTH] ^ r[WIDTH*i +: WIDTH];
            acc                   = acc ^ r[WIDTH*i +: WIDTH];
        end
        res[WIDTH*(NSHARE-1) +: WIDTH] = w[WIDTH*(NSHARE-1) +: WIDTH] ^ acc;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ti_share_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : ti_share_pipe_reg_if
// Purpose  : Handshake bundle of the TI share pipeline register.
//            master = surrounding logic (stage-1, RNG, stage-2 side)
//            slave  = the pipeline register itself
// Signals  : in_valid/in_ready/in_shares  - stage-1 word handshake
//            rnd/rnd_valid/rnd_ready      - fresh randomness handshake
//            out_valid/out_ready/out_shares - stage-2 word handshake
//            xfer_cnt                     - accepted word counter
// Revision : 1.0 - initial release
// ============================================================================
interface ti_share_pipe_reg_if;
    import ti_pkg::*;

    logic        in_valid;
    logic        in_ready;
    share_word_t in_shares;
    rnd_word_t   rnd;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        out_valid;
    logic        out_ready;
    share_word_t out_shares;
    logic [15:0] xfer_cnt;

    modport master (
        output in_valid, in_shares, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ready, out_valid, out_shares, xfer_cnt
    );

    modport slave (
        input  in_valid, in_shares, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ready, out_valid, out_shares, xfer_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ti_share_pipe_reg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ti_share_fifo
// Purpose  : DEPTH-entry shift FIFO of shared words. Entry 0 is the head and
//            drives the output register directly. Vacated entries are
//            zeroised on the popping edge, so an empty FIFO presents zero.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            wr_en_i, wr_data_i  - write strobe / word (ignored when full)
//            full_o              - no free entry
//            rd_ready_i          - consumer takes head this cycle
//            rd_valid_o, rd_data_o - head valid / head word (registered)
// Revision : 1.0 - initial release
// ============================================================================
module ti_share_fifo
    import ti_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  share_word_t wr_data_i,
    output logic        full_o,
    input  logic        rd_ready_i,
    output logic        rd_valid_o,
    output share_word_t rd_data_o
);

    localparam int CW = $clog2(DEPTH + 1);

    share_word_t   mem_q [DEPTH];
    share_word_t   mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] w_wr_idx;
    logic          w_pop;
    logic          w_push;

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[0];
    assign full_o     = (count_q == CW'(DEPTH));
    assign w_pop      = rd_valid_o & rd_ready_i;
    assign w_push     = wr_en_i & ~full_o;

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        w_wr_idx = count_q;
        if (w_pop) begin
            // Whole queue moves one slot toward the head; the tail slot it
            // leaves behind is cleared so no stale share survives.
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
            w_wr_idx       = count_q - CW'(1);
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_wr_idx) begin
                    mem_d[i] = wr_data_i;
                end
            end
        end
        count_d = count_q + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ti_share_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : ti_share_pipe_reg
// Purpose  : Registered glitch barrier between the two TI S-box stages.
//            Accepts 3-share words from stage 1, optionally remasks them with
//            fresh randomness, buffers up to DEPTH words and hands them to
//            stage 2 over valid/ready.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous reset, active-high
//            bus  - ti_share_pipe_reg_if.slave (in/rnd/out handshakes,
//                   xfer_cnt accepted-word counter)
// Params   : DEPTH   - buffered words (1 or 2)
//            REFRESH - 1: remask each accepted word with rnd, 0: pass-through
// Revision : 1.0 - initial release
// ============================================================================
module ti_share_pipe_reg
    import ti_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int REFRESH = 1
) (
    input  logic                clk,
    input  logic                rst,
    ti_share_pipe_reg_if.slave  bus
);

    logic        w_full;
    logic        w_rnd_ok;
    logic        w_push;
    share_word_t w_wr_word;
    logic [15:0] xfer_cnt_q;
    logic [15:0] xfer_cnt_d;

    // Acceptance depends only on registered occupancy and rnd_valid; the
    // downstream ready is deliberately kept out of this path.
    assign w_rnd_ok      = (REFRESH == 0) ? 1'b1 : bus.rnd_valid;
    assign bus.in_ready  = ~rst & ~w_full & w_rnd_ok;
    assign w_push        = bus.in_valid & bus.in_ready;
    assign bus.rnd_ready = (REFRESH != 0) ? w_push : 1'b0;

    generate
        if (REFRESH != 0) begin : g_refresh
            assign w_wr_word = share_refresh(bus.in_shares, bus.rnd);
        end else begin : g_pass
            assign w_wr_word = bus.in_shares;
        end
    endgenerate

    ti_share_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (w_push),
        .wr_data_i  (w_wr_word),
        .full_o     (w_full),
        .rd_ready_i (bus.out_ready),
        .rd_valid_o (bus.out_valid),
        .rd_data_o  (bus.out_shares)
    );

    assign xfer_cnt_d   = w_push ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
    assign bus.xfer_cnt = xfer_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ti_share_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ti_share_pipe_reg
// Purpose  : Self-checking bench for ti_share_pipe_reg (DEPTH=2, REFRESH=1).
//            Accepted words are predicted by a share-level model and queued;
//            a negedge monitor compares the head and handshakes each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ti_share_pipe_reg;
    import ti_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    ti_share_pipe_reg_if bus ();

    ti_share_pipe_reg #(
        .DEPTH   (DEPTH),
        .REFRESH (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: three 4-bit shares, masks r0/r1; s2 takes both masks.
    function automatic logic [11:0] ref_word(input logic [11:0] w, input logic [7:0] r);
        logic [3:0] s0, s1, s2, r0, r1;
        r0 = r[3:0];
        r1 = r[7:4];
        s0 = w[3:0]  ^ r0;
        s1 = w[7:4]  ^ r1;
        s2 = w[11:8] ^ r0 ^ r1;
        return {s2, s1, s0};
    endfunction

    function automatic logic [3:0] unmask(input logic [11:0] w);
        return w[3:0] ^ w[7:4] ^ w[11:8];
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [11:0] exp_q [$];
    logic [3:0]  val_q [$];
    logic [15:0] m_cnt = 16'd0;

    always @(negedge clk) begin
        logic exp_rdy;
        logic acc;
        if (rst) begin
            chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
            chk("rnd_ready_in_reset", {31'd0, bus.rnd_ready}, 32'd0);
            exp_q.delete();
            val_q.delete();
            m_cnt = 16'd0;
        end else begin
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0)
                chk("out_shares", {20'd0, bus.out_shares}, {20'd0, exp_q[0]});
            else
                chk("out_shares_empty_zero", {20'd0, bus.out_shares}, 32'd0);
            chk("xfer_cnt", {16'd0, bus.xfer_cnt}, {16'd0, m_cnt});
            exp_rdy = (exp_q.size() < DEPTH) && bus.rnd_valid;
            acc     = bus.in_valid && exp_rdy;
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            chk("rnd_ready", {31'd0, bus.rnd_ready}, {31'd0, acc});
            if (exp_q.size() != 0 && bus.out_ready) begin
                chk("share_xor_preserved", {28'd0, unmask(bus.out_shares)}, {28'd0, val_q[0]});
                void'(exp_q.pop_front());
                void'(val_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(ref_word(bus.in_shares, bus.rnd));
                val_q.push_back(unmask(bus.in_shares));
                m_cnt = m_cnt + 16'd1;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected end");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_word();
        bus.in_shares = 12'($urandom);
        bus.rnd       = 8'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] base;
        int          k;
        bus.in_valid  = 1'b0;
        bus.in_shares = '0;
        bus.rnd       = '0;
        bus.rnd_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Reset then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_out_shares", {20'd0, bus.out_shares}, 32'd0);
        chk("reset_xfer_cnt", {16'd0, bus.xfer_cnt}, 32'd0);

        // Single refreshed word
        bus.in_shares = 12'h953;
        bus.rnd       = 8'hA6;
        bus.rnd_valid = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("single_rnd_ready", {31'd0, bus.rnd_ready}, 32'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
        #1;
        chk("single_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_out_shares", {20'd0, bus.out_shares}, 32'h5F5);
        chk("single_xfer_cnt", {16'd0, bus.xfer_cnt}, 32'd1);
        chk("single_rnd_ready_drop", {31'd0, bus.rnd_ready}, 32'd0);

        // Randomness starvation
        bus.in_valid  = 1'b1;
        bus.in_shares = 12'hABC;
        repeat (5) begin
            #1;
            chk("starve_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("starve_rnd_ready", {31'd0, bus.rnd_ready}, 32'd0);
            tick();
        end
        chk("starve_no_push", {16'd0, bus.xfer_cnt}, 32'd1);
        bus.rnd       = 8'h3C;
        bus.rnd_valid = 1'b1;
        #1;
        chk("unstarve_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
        chk("unstarve_push", {16'd0, bus.xfer_cnt}, 32'd2);
        repeat (3) tick();

        // Backpressure / full
        bus.out_ready = 1'b0;
        bus.rnd       = 8'h00;
        bus.rnd_valid = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_shares = 12'h111;
        tick();
        bus.in_shares = 12'h222;
        tick();
        bus.in_shares = 12'h333;
        #1;
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full_rnd_ready", {31'd0, bus.rnd_ready}, 32'd0);
        repeat (3) tick();
        chk("full_head_held", {20'd0, bus.out_shares}, 32'h111);
        chk("full_xfer_cnt", {16'd0, bus.xfer_cnt}, 32'd4);
        bus.out_ready = 1'b1;
        tick();
        chk("pop1_head", {20'd0, bus.out_shares}, 32'h222);
        chk("vacated_entry_zero", {20'd0, u_dut.u_fifo.mem_q[1]}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("pop2_head", {20'd0, bus.out_shares}, 32'h333);
        tick();
        chk("drained_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Streaming 100 words, one per cycle
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        base          = bus.xfer_cnt;
        repeat (100) begin
            rand_word();
            tick();
        end
        bus.in_valid = 1'b0;
        chk("stream_throughput", {16'd0, bus.xfer_cnt - base}, 32'd100);

        // Random handshake mix
        repeat (400) begin
            rand_word();
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.rnd_valid = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        k = 0;
        while (bus.out_valid && k < 10) begin
            tick();
            k++;
        end
        chk("drain_within_budget", {31'd0, bus.out_valid}, 32'd0);

        // Reset with two buffered words
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        rand_word();
        tick();
        rand_word();
        tick();
        bus.in_valid = 1'b0;
        chk("pre_reset_full", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midreset_out_shares", {20'd0, bus.out_shares}, 32'd0);
        chk("midreset_xfer_cnt", {16'd0, bus.xfer_cnt}, 32'd0);

        // Counter wrap after 65536 pushes
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        repeat (65535) begin
            rand_word();
            tick();
        end
        chk("cnt_at_ffff", {16'd0, bus.xfer_cnt}, 32'hFFFF);
        rand_word();
        tick();
        bus.in_valid = 1'b0;
        chk("cnt_wrapped", {16'd0, bus.xfer_cnt}, 32'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
